// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and stored active-high.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Entry n is the glyph for hex digit n (entry 0 is the rightmost element).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/seg7_scan_if.sv
// Core-side bundle of the display driver: packed digit data and masks in,
// multiplexed segment/common pins and the frame marker out.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic                load;
  logic [6:0]          seg_out;
  logic                dp_out;
  logic [DIGITS-1:0]   com_out;
  logic                frame_done;

  modport master (
    output data_in, dp_in, blank_in, load,
    input  seg_out, dp_out, com_out, frame_done
  );

  modport slave (
    input  data_in, dp_in, blank_in, load,
    output seg_out, dp_out, com_out, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high {g..a} segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment driver: double-buffered digit data, per-slot
// ghost blanking, registered pins.
//   state | meaning
//   BLANK | start of slot, all commons/segments off
//   DRIVE | common idx enabled, segments show digit idx
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 10000,
  parameter int BLANK_CYCLES   = 50,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SET_W = 6 * DIGITS;

  localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST       = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF        = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic              DP_OFF         = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] COM_OFF        = (COM_ACTIVE_LOW != 0) ? '1 : '0;
  // Register set layout {data, dp, blank}; the display powers up fully blanked.
  localparam logic [SET_W-1:0]  DISP_RST       = {{(5*DIGITS){1'b0}}, {DIGITS{1'b1}}};

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  scan_state_e       state_q, state_d;
  logic [SET_W-1:0]  pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [SET_W-1:0]  disp_q, disp_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] com_q, com_d;
  logic              fd_q, fd_d;

  logic [SET_W-1:0]    load_set;
  logic [4*DIGITS-1:0] disp_data;
  logic [DIGITS-1:0]   disp_dp;
  logic [DIGITS-1:0]   disp_blank;
  logic [3:0]          nibble;
  logic [6:0]          seg_dec;
  logic                boundary;

  assign load_set   = {bus.data_in, bus.dp_in, bus.blank_in};
  assign disp_data  = disp_q[SET_W-1 -: 4*DIGITS];
  assign disp_dp    = disp_q[2*DIGITS-1 -: DIGITS];
  assign disp_blank = disp_q[DIGITS-1:0];
  assign nibble     = 4'(disp_data >> {idx_q, 2'b00});

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= DISP_RST;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      com_q        <= COM_OFF;
      fd_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      com_q        <= com_d;
      fd_q         <= fd_d;
    end
  end

  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    boundary     = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    case (state_q)
      BLANK:   if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
      DRIVE:   if (cnt_q == CNT_LAST) state_d = BLANK;
      default: state_d = BLANK;
    endcase

    // Display only swaps at the frame edge; a load on that very cycle wins.
    if (boundary) begin
      disp_d       = bus.load ? load_set : (pend_valid_q ? pend_q : disp_q);
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_d       = load_set;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    com_d = '0;
    if (state_q == DRIVE) begin
      com_d = DIGITS'(1) << idx_q;
      if (!disp_blank[idx_q]) begin
        seg_d = seg_dec;
        dp_d  = disp_dp[idx_q];
      end
    end
    seg_d = seg_d ^ SEG_OFF;
    dp_d  = dp_d ^ DP_OFF;
    com_d = com_d ^ COM_OFF;
    fd_d  = boundary;
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.com_out    = com_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: an active-low and an active-high instance share
// stimulus and are scored every cycle against a frame-level display model.
module tb_seg7_scan;

  localparam int DIG   = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = DIG * DIV;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] com;
    logic       fd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks   = 0;
  int failures = 0;

  logic [6:0] lut [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                           7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Model: k = clock edges since reset release; what is shown per frame.
  int         k = 0;
  logic [15:0] sh_data = '0, pd_data = '0;
  logic [3:0]  sh_dp = '0, sh_bl = '1, pd_dp = '0, pd_bl = '0;
  bit          pv = 1'b0;
  exp_t        exp_q[$];

  seg7_scan_if #(.DIGITS(DIG)) if_lo ();
  seg7_scan_if #(.DIGITS(DIG)) if_hi ();

  seg7_scan #(.DIGITS(DIG), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK),
              .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .bus(if_lo.slave));

  seg7_scan #(.DIGITS(DIG), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK),
              .SEG_ACTIVE_LOW(0), .COM_ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .bus(if_hi.slave));

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at k=%0d", k);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  // Expected pins after the next edge follow from the model state before it.
  initial begin
    int   pos, slot;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0; sh_data = '0; sh_dp = '0; sh_bl = '1; pv = 1'b0;
        exp_q.delete();
      end else begin
        pos  = k % FRAME;
        slot = pos / DIV;
        e    = '0;
        if ((pos % DIV) >= BLK) begin
          e.com = 4'(1 << slot);
          if (!sh_bl[slot]) begin
            e.seg = lut[sh_data[slot*4 +: 4]];
            e.dp  = sh_dp[slot];
          end
        end
        e.fd = ((k + 1) % FRAME) == 0;
        exp_q.push_back(e);
        if (pos == FRAME - 1) begin
          if (if_lo.load) begin
            sh_data = if_lo.data_in; sh_dp = if_lo.dp_in; sh_bl = if_lo.blank_in;
          end else if (pv) begin
            sh_data = pd_data; sh_dp = pd_dp; sh_bl = pd_bl;
          end
          pv = 1'b0;
        end else if (if_lo.load) begin
          pd_data = if_lo.data_in; pd_dp = if_lo.dp_in; pd_bl = if_lo.blank_in;
          pv = 1'b1;
        end
        k++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_lo", 32'({if_lo.seg_out, if_lo.dp_out, if_lo.com_out, if_lo.frame_done}), 32'h1ffe);
        chk("rst_hi", 32'({if_hi.seg_out, if_hi.dp_out, if_hi.com_out, if_hi.frame_done}), 32'h0);
      end else if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow k=%0d got=empty want=entry", k);
      end else begin
        e = exp_q.pop_front();
        chk("sb_lo", 32'({if_lo.seg_out, if_lo.dp_out, if_lo.com_out, if_lo.frame_done}),
            32'({~e.seg, ~e.dp, ~e.com, e.fd}));
        chk("sb_hi", 32'({if_hi.seg_out, if_hi.dp_out, if_hi.com_out, if_hi.frame_done}),
            32'(e));
      end
    end
  end

  task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                        input logic ld);
    if_lo.data_in = d; if_lo.dp_in = p; if_lo.blank_in = b; if_lo.load = ld;
    if_hi.data_in = d; if_hi.dp_in = p; if_hi.blank_in = b; if_hi.load = ld;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    set_in(d, p, b, 1'b1);
    @(posedge clk); #1;
    set_in(d, p, b, 1'b0);
  endtask

  task automatic wait_k(input int v);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((k % FRAME) != v && n < 3 * FRAME);
    if ((k % FRAME) != v) begin
      checks++; failures++;
      $display("FAIL wait_k got=%0d want=%0d", k % FRAME, v);
    end
  endtask

  task automatic check_at(input int v, input string nm, input logic [6:0] s,
                          input logic d, input logic [3:0] c);
    wait_k(v);
    chk(nm, 32'({if_lo.seg_out, if_lo.dp_out, if_lo.com_out}), 32'({s, d, c}));
  endtask

  initial begin
    int fdc = 0;
    set_in(16'h0, 4'h0, 4'h0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Dark after reset; frame marker every FRAME cycles.
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (if_lo.frame_done) fdc++;
    end
    chk("fd_count", 32'(fdc), 32'd3);

    do_load(16'h1A3F, 4'b0100, 4'b0000);
    wait_k(FRAME - 1);
    check_at(1,  "gap_s0",  7'b1111111, 1'b1, 4'b1111);
    check_at(3,  "dig0_F",  7'b0001110, 1'b1, 4'b1110);
    check_at(11, "dig1_3",  7'b0110000, 1'b1, 4'b1101);
    check_at(19, "dig2_A",  7'b0001000, 1'b0, 4'b1011);
    check_at(27, "dig3_1",  7'b1111001, 1'b1, 4'b0111);

    // Last load in a frame wins; boundary-cycle load is immediate.
    wait_k(4);  do_load(16'h1111, 4'h0, 4'h0);
    wait_k(20); do_load(16'h2222, 4'h0, 4'h0);
    check_at(3, "two_load", 7'b0100100, 1'b1, 4'b1110);
    wait_k(FRAME - 1); do_load(16'h8888, 4'h0, 4'h0);
    check_at(3, "bnd_load", 7'b0000000, 1'b1, 4'b1110);
    chk("hi_drive", 32'({if_hi.seg_out, if_hi.dp_out, if_hi.com_out}), 32'({7'h7f, 1'b0, 4'b0001}));
    wait_k(9);
    chk("hi_blank", 32'({if_hi.seg_out, if_hi.dp_out, if_hi.com_out}), 32'h0);

    // Blanked digit keeps its common but stays dark, dp included.
    wait_k(10); do_load(16'h9E47, 4'b1000, 4'b1000);
    wait_k(FRAME - 1);
    check_at(27, "blank_d3", 7'b1111111, 1'b1, 4'b0111);

    repeat (40) begin
      repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 4) == 0) wait_k(FRAME - 1);
      do_load(16'($urandom), 4'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end
    wait_k(FRAME - 1);
    wait_k(FRAME - 1);

    // Asynchronous reset in the middle of digit 2's slot.
    do_load(16'h5678, 4'h0, 4'h0);
    wait_k(FRAME - 1);
    wait_k(19);
    #2 rst_n = 1'b0;
    #1;
    chk("async_lo", 32'({if_lo.seg_out, if_lo.dp_out, if_lo.com_out, if_lo.frame_done}), 32'h1ffe);
    chk("async_hi", 32'({if_hi.seg_out, if_hi.dp_out, if_hi.com_out, if_hi.frame_done}), 32'h0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * FRAME) @(posedge clk);
    #1;
    do_load(16'hC0DE, 4'b0011, 4'h0);
    wait_k(FRAME - 1);
    wait_k(FRAME - 1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed 7-segment display driver: takes a packed hex value plus per-digit decimal-point and blank masks from the core, and time-multiplexes them onto a common-electrode LED display, one digit at a time. It is the output-side counterpart of the front-panel input conditioning: debounced buttons come in, human-readable status goes out. It sits at the board-I/O boundary on the 10 MHz system clock.

## Interface
- DIGITS, 4: number of digits, legal 1..8.
- SCAN_DIV, 10000: clock cycles per digit slot (1 ms at 10 MHz); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 50: ghost-suppression cycles at the start of each slot with all commons off; legal 1..SCAN_DIV-1.
- SEG_ACTIVE_LOW, 1: 1 means segment/dp outputs drive 0 to light.
- COM_ACTIVE_LOW, 1: 1 means common outputs drive 0 to enable.
- clk  in  1  system clock, 10 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = LSB nibble).
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  DIGITS  1 = digit fully dark, including its dp.
- load  in  1  single-cycle strobe; captures data_in/dp_in/blank_in.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp_out  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
- com_out  out  DIGITS  digit enables, one-hot or none, polarity per COM_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse on the first cycle of each new frame.

## Operation
- Three register sets: pending (written by load), display (currently scanned), and a pending_valid flag.
- load: pending <= {data_in, dp_in, blank_in}; pending_valid <= 1. A second load before the frame boundary overwrites pending; the last one wins.
- Frame boundary: the cycle where idx == DIGITS-1 and cnt == SCAN_DIV-1. On it, display <= the load inputs if load is high that cycle, else pending if pending_valid. pending_valid <= 0. Display never changes mid-frame, so there is no tearing.
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps. Digit index idx increments on cnt wrap and wraps DIGITS-1 -> 0.
- FSM per slot:
  - BLANK (cnt < BLANK_CYCLES): all commons inactive; segments and dp inactive.
  - DRIVE (cnt >= BLANK_CYCLES): com_out enables digit idx only.
  - If blank[idx] = 1, segments and dp stay inactive but the common is still enabled.
  - Otherwise seg_out = decode(nibble idx) and dp_out = dp[idx].
- Decode (active-high form, {g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - Inverted when SEG_ACTIVE_LOW = 1.
- All outputs are registered, with no combinational path from inputs to pins.

## Timing
- Reset state:
  - cnt = 0, idx = 0, FSM = BLANK.
  - display blank mask all 1, data 0, dp 0; pending cleared; pending_valid = 0.
  - seg_out, dp_out, com_out all inactive; frame_done = 0.
- Outputs lag internal state by one register stage. The common for slot idx becomes active on the cycle after cnt reaches BLANK_CYCLES and goes inactive on the cycle after cnt wraps.
- Frame period is DIGITS*SCAN_DIV cycles. frame_done is high for exactly one cycle, coinciding with idx = 0, cnt = 0.
- Load-to-visible latency ranges from 1 to DIGITS*SCAN_DIV cycles, depending on where the frame boundary falls.
- rst_n asserted mid-frame: all outputs go inactive immediately (asynchronously) and the pending load is discarded. After deassertion, the display stays dark until the first load has crossed a frame boundary.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant, active-high;
  - the FSM state type {BLANK, DRIVE};
  - the segment bit-order localparams.
- Sub-module seg7_decode is a combinational nibble-to-7-segment decoder (active-high), instantiated once on the idx-muxed nibble.
- Polarity inversion is applied at the top level, at the output registers.

## Test plan
Parameters for all scenarios: DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, both polarities active-low unless stated.
1. Reset release with no load: for 3 frames, com_out = 1111, seg_out = 1111111, dp_out = 1; frame_done pulses every 32 cycles.
2. load with data_in = 16'h1A3F, dp_in = 0100, blank_in = 0000:
   - Frame 1 is still dark.
   - Frame 2 shows digit0 seg = 0001110 (F), digit1 = 0110000 (3), digit2 = 0001000 (A) with dp_out = 0, digit3 = 1111001 (1).
   - com_out walks 1110 -> 1101 -> 1011 -> 0111, with 2 all-off cycles per slot.
3. Two loads in one frame (16'h1111, then 16'h2222): only 2222 is ever displayed. A load on the exact boundary cycle takes effect in that same new frame.
4. blank_in = 1000 with dp_in = 1000: digit3's common is enabled, but seg_out = 1111111 and dp_out = 1 throughout its slot.
5. With SEG_ACTIVE_LOW = 0 and COM_ACTIVE_LOW = 0, data 16'h8888: seg_out = 1111111 and one-hot active-high com_out during DRIVE; all zeros during BLANK.
6. rst_n pulsed low mid-slot of digit 2: outputs go inactive asynchronously. After release, cnt and idx restart from 0, and the display stays dark until a new load reaches a frame boundary.
